// File: rtl/fp_div_arbiter_pkg.sv
// fp_div_pkg: shared types and constants for the FP divider arbiter.
//   state_t    - controller state encoding (IDLE / RUN / DONE)
//   DIV_STEPS  - step count of the iterative divider
//   EXP_*, SIGN_BIT, INF_MAG - single-precision field positions and the
//                infinity magnitude used for divide-by-zero results.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_STEPS = 25;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;
    localparam int SIGN_BIT  = 31;

    localparam logic [30:0] INF_MAG = 31'h7F800000;

endpackage

// File: rtl/fp_div_arbiter_if.sv
// fp_div_arbiter_if: requester-side bus of the shared FP divider.
//   req   - level request per requester
//   x_in  - packed dividends, slice i = requester i
//   y_in  - packed divisors,  slice i = requester i
//   ack   - one-cycle completion pulse to the granted requester
//   res   - quotient, valid while any ack bit is high
//   busy  - arbiter is running or finishing an operation
//
// Handshake: a requester raises req[i] with stable operands and keeps it
// high until it sees ack[i]; ack[i] is high for exactly one enabled cycle
// and res is valid in that cycle. Dropping req early does not cancel the
// operation already granted.
interface fp_div_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] x_in;
    logic [32*NREQ-1:0] y_in;
    logic [NREQ-1:0]    ack;
    logic [31:0]        res;
    logic               busy;

    modport master (
        output req, x_in, y_in,
        input  ack, res, busy
    );

    modport slave (
        input  req, x_in, y_in,
        output ack, res, busy
    );
endinterface

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    - request vector
//   last   - index granted last time
//   any    - at least one request is pending
//   gnt_id - first requesting index after last, wrapping around
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  gnt_id
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                start;

    // Rotate the request vector so bit 0 is the slot right after last,
    // then take the lowest set bit of the rotated vector.
    always_comb begin
        any    = |req;
        gnt_id = '0;
        start  = (int'(last) + 1) % NREQ;
        dbl    = {req, req};
        rot    = NREQ'(dbl >> start);
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_id = IDW'((start + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one iterative FP divider among NREQ requesters.
//   clk, rst (async, active low), ce (clock enable for everything)
//   bus       - requester bus (req/x_in/y_in in, ack/res/busy out)
//   div_ce    - divider clock enable, equal to ce
//   div_run   - registered run to the divider
//   div_x/y   - operands latched at grant, stable for the whole divide
//   div_stall - divider still iterating
//   div_z     - divider quotient
//   dbg_state - current controller state
// Optional build macro FPDIV_ZERO_BYPASS_EN: zero-exponent operands are
// resolved in IDLE without starting the divider.
module fp_div_arbiter
    import fp_div_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    fp_div_arbiter_if.slave    bus,
    output logic               div_ce,
    output logic               div_run,
    output logic [31:0]        div_x,
    output logic [31:0]        div_y,
    input  logic               div_stall,
    input  logic [31:0]        div_z,
    output state_t             dbg_state
);

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              run_q, run_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [31:0]       res_q, res_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;

    logic              any;
    logic [IDW-1:0]    gnt_id;
    logic [31:0]       win_x, win_y;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (bus.req),
        .last   (last_q),
        .any    (any),
        .gnt_id (gnt_id)
    );

    assign win_x = 32'(bus.x_in >> (32 * int'(gnt_id)));
    assign win_y = 32'(bus.y_in >> (32 * int'(gnt_id)));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        run_d   = run_q;
        ack_d   = '0;
        res_d   = res_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    x_d    = win_x;
                    y_d    = win_y;
                    id_d   = gnt_id;
                    last_d = gnt_id;
`ifdef FPDIV_ZERO_BYPASS_EN
                    if (win_x[EXP_MSB:EXP_LSB] == '0) begin
                        res_d   = '0;
                        ack_d   = NREQ'(1) << gnt_id;
                        state_d = DONE;
                    end else if (win_y[EXP_MSB:EXP_LSB] == '0) begin
                        res_d   = {win_x[SIGN_BIT] ^ win_y[SIGN_BIT], INF_MAG};
                        ack_d   = NREQ'(1) << gnt_id;
                        state_d = DONE;
                    end else begin
                        run_d   = 1'b1;
                        state_d = RUN;
                    end
`else
                    run_d   = 1'b1;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (!div_stall) begin
                    res_d   = div_z;
                    ack_d   = NREQ'(1) << id_q;
                    run_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // run stays low one more cycle so the divider's step
                // counter is back at zero before the next grant
                state_d = IDLE;
            end
            default: begin
                run_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            run_q   <= 1'b0;
            ack_q   <= '0;
            res_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (ce) begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            run_q   <= run_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.res   = res_q;
    assign bus.busy  = (state_q == RUN) || (state_q == DONE);
    assign div_ce    = ce;
    assign div_run   = run_q;
    assign div_x     = x_q;
    assign div_y     = y_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: bench for fp_div_arbiter with a behavioural divider
// stand-in (stalls for DIV_STEPS enabled cycles after run rises) and a
// transaction-level model of round-robin order, quotient and latency.
module tb_fp_div_arbiter;
    import fp_div_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 2;
    localparam int W    = NREQ + 32;
`ifdef FPDIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b1;
    logic        div_ce, div_run, div_stall;
    logic [31:0] div_x, div_y, div_z;
    state_t      dbg_state;

    fp_div_arbiter_if #(.NREQ(NREQ)) bus ();

    fp_div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .bus       (bus),
        .div_ce    (div_ce),
        .div_run   (div_run),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_stall (div_stall),
        .div_z     (div_z),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] num;
        logic [23:0] den;
        logic [24:0] q;
        logic [22:0] mant;
        int          e;
        if (x[30:23] == 8'h00) return 32'h0;
        if (y[30:23] == 8'h00) return {x[31] ^ y[31], 8'hFF, 23'h0};
        num = {1'b1, x[22:0], 24'h0};
        den = {1'b1, y[22:0]};
        q   = 25'(num / 48'(den));
        e   = int'(x[30:23]) - int'(y[30:23]) + 127;
        if (q[24]) mant = q[23:1];
        else begin
            mant = q[22:0];
            e    = e - 1;
        end
        return {x[31] ^ y[31], e[7:0], mant};
    endfunction

    // ---------------- divider stand-in ----------------
    int step_cnt = 0;
    always @(posedge clk) if (div_ce) step_cnt <= div_run ? step_cnt + 1 : 0;
    assign div_stall = div_run && (step_cnt < DIV_STEPS);
    assign div_z     = div_stall ? 32'h5A5A5A5A : ref_div(div_x, div_y);

    // ---------------- edge counters ----------------
    int ce_edges = 0, clk_edges = 0, run_edges = 0;
    always @(posedge clk) begin
        clk_edges++;
        if (ce) ce_edges++;
        if (ce && div_run) run_edges++;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]    exp_q[$];
    int              n_vec = 0, n_err = 0;
    int              model_last = NREQ - 1;
    logic [NREQ-1:0] req_v = '0;
    logic [31:0]     xv[NREQ];
    logic [31:0]     yv[NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (((r >> j) & NREQ'(1)) != '0) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(100, 150));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < NREQ; i++) begin
            bus.x_in[i*32 +: 32] = xv[i];
            bus.y_in[i*32 +: 32] = yv[i];
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        ce    = 1'b1;
        req_v = '0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b1;
        model_last = NREQ - 1;
    endtask

    task automatic wait_ack(input int ce_low_n, input int ref_e, input int poke_at,
                            input int poke_id, input logic [31:0] poke_val,
                            output bit ok, output int lows);
        int guard;
        bit poked;
        ok = 1'b0; lows = 0; guard = 0; poked = 1'b0;
        while (!ok && guard < 400) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
            if (|bus.ack) ok = 1'b1;
            else begin
                if (poke_at >= 0 && !poked && ce_edges - ref_e == poke_at) begin
                    xv[poke_id] = poke_val;
                    drive();
                    poked = 1'b1;
                end
                if (lows < ce_low_n && div_run &&
                    ($urandom_range(0, 1) == 1 || ce_edges - ref_e >= 15)) begin
                    ce = 1'b0;
                    lows++;
                    #1 check("div_ce_low", 64'(div_ce), 64'(0));
                end else begin
                    ce = 1'b1;
                end
            end
        end
        ce = 1'b1;
        if (!ok) check("ack_timeout", 64'(0), 64'(1));
    endtask

    // Caller has applied req_v/operands at a negedge with the arbiter idle.
    task automatic run_ops(input int n_ops, input bit hold, input int ce_low_n,
                           input int poke_at, input logic [31:0] poke_val);
        int ref_e, ref_c, ref_r, win, lows, exp_edges;
        bit ok, byp;
        logic [W-1:0] exp_e;
        ref_e = ce_edges; ref_c = clk_edges; ref_r = run_edges;
        for (int op = 0; op < n_ops; op++) begin
            win        = rr_pick(req_v, model_last);
            model_last = win;
            byp        = BYP && (xv[win][30:23] == 8'h00 || yv[win][30:23] == 8'h00);
            exp_q.push_back({NREQ'(1) << win, ref_div(xv[win], yv[win])});
            exp_edges  = (op == 0) ? (byp ? 1 : 27) : (byp ? 2 : 28);
            wait_ack((op == 0) ? ce_low_n : 0, ref_e, (op == 0) ? poke_at : -1,
                     win, poke_val, ok, lows);
            if (!ok) begin
                exp_q.delete();
                do_reset();
                return;
            end
            exp_e = exp_q.pop_front();
            check("ack", 64'(bus.ack), 64'(exp_e[W-1:32]));
            check("res", 64'(bus.res), 64'(exp_e[31:0]));
            check("latency", 64'(ce_edges - ref_e), 64'(exp_edges));
            check("cycles", 64'(clk_edges - ref_c), 64'(exp_edges + lows));
            check("run_len", 64'(run_edges - ref_r), 64'(byp ? 0 : 26));
            if (op == 0 && ce_low_n > 0 && !byp) check("ce_lows", 64'(lows), 64'(ce_low_n));
            ref_e = ce_edges; ref_c = clk_edges; ref_r = run_edges;
            if (!hold) req_v[win] = 1'b0;
            if (hold && op == n_ops - 1) req_v = '0;
            drive();
            @(posedge clk);
            @(negedge clk);
            check("ack_pulse", 64'(bus.ack), 64'(0));
            check("run_gap", 64'(div_run), 64'(0));
            check("res_hold", 64'(bus.res), 64'(exp_e[31:0]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ref_e, guard;
        for (int i = 0; i < NREQ; i++) begin
            xv[i] = '0;
            yv[i] = '0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(bus.ack), 64'(0));
        check("rst_res", 64'(bus.res), 64'(0));
        check("rst_run", 64'(div_run), 64'(0));
        check("rst_x", 64'(div_x), 64'(0));
        check("rst_y", 64'(div_y), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b1;

        // 1.0 / 2.0 on requester 0
        xv[0] = 32'h3F800000; yv[0] = 32'h40000000; req_v = 2'b01; drive();
        run_ops(1, 1'b0, 0, -1, 32'h0);

        // simultaneous requests from reset priority, then held alternation
        do_reset();
        xv[0] = 32'h40C00000; yv[0] = 32'h40400000;
        xv[1] = 32'h3F800000; yv[1] = 32'h40000000;
        req_v = 2'b11; drive();
        run_ops(2, 1'b0, 0, -1, 32'h0);
        req_v = 2'b11; drive();
        run_ops(4, 1'b1, 0, -1, 32'h0);

        // divide by zero
        xv[0] = 32'hBF800000; yv[0] = 32'h00000000; req_v = 2'b01; drive();
        run_ops(1, 1'b0, 0, -1, 32'h0);

        // ten clock-enable-low cycles during the divide
        xv[0] = 32'h40C00000; yv[0] = 32'h40400000; req_v = 2'b01; drive();
        run_ops(1, 1'b0, 10, -1, 32'h0);

        // operand change two cycles after grant must not matter
        xv[1] = 32'h40C00000; yv[1] = 32'h40000000; req_v = 2'b10; drive();
        run_ops(1, 1'b0, 0, 3, 32'h41200000);

        // reset in the middle of RUN
        xv[0] = 32'h3F800000; yv[0] = 32'h40000000; req_v = 2'b01; drive();
        ref_e = ce_edges; guard = 0;
        while (ce_edges - ref_e < 13 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2 rst = 1'b0;
        #1;
        check("abort_run", 64'(div_run), 64'(0));
        check("abort_ack", 64'(bus.ack), 64'(0));
        check("abort_res", 64'(bus.res), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        req_v = '0; drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_last = NREQ - 1;
        xv[0] = 32'h40C00000; yv[0] = 32'h40400000;
        xv[1] = 32'h3F800000; yv[1] = 32'h40000000;
        req_v = 2'b11; drive();
        run_ops(2, 1'b0, 0, -1, 32'h0);

        // randomized batches
        for (int b = 0; b < 12; b++) begin
            bit hold;
            int n;
            for (int i = 0; i < NREQ; i++) begin
                xv[i] = rand_fp();
                yv[i] = rand_fp();
            end
            req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            hold  = 1'($urandom_range(0, 1));
            n     = hold ? 3 : $countones(req_v);
            drive();
            run_ops(n, hold, $urandom_range(0, 4), -1, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
Shares one iterative FP divider (25-step restoring, single-precision Oberon format) among NREQ requesters, for example the CPU FPU path and a coprocessor/DMA scaler. It does three things:
- Round-robin arbitration of level requests.
- Latching the winner's operands and holding them stable for the whole divide.
- Sequencing the divider's run/stall protocol, including the mandatory one-cycle run-low gap between operations.

The result is returned with a one-cycle ack pulse to the granted requester.

Parameters:
NREQ, 2, number of requesters (2..4).
IDW, 2, width of grant index; must satisfy 2**IDW >= NREQ.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ce  in  1  clock enable; controller and divider advance only when high
req  in  NREQ  level request per requester, held until its ack
x_in  in  32*NREQ  dividend per requester (slice i = requester i)
y_in  in  32*NREQ  divisor per requester
ack  out  NREQ  one-cycle pulse (while ce) to the requester whose result is on res
res  out  32  quotient register, valid when any ack bit is high, held until next completion
busy  out  1  high in RUN or DONE
div_ce  out  1  = ce
div_run  out  1  registered run to divider
div_x  out  32  latched dividend
div_y  out  32  latched divisor
div_stall  in  1  divider stall
div_z  in  32  divider quotient

Behaviour:
- Reset (rst low, async): state IDLE; div_run=0, ack=0, res=0, div_x=div_y=0, rr pointer=NREQ-1 (so requester 0 has first priority). Deasserting div_run lets the divider's step counter clear on its next ce edge.
- All register updates are qualified by ce. When ce is low, every register holds.
- IDLE:
  - If req is nonzero, grant the first set bit searching from (last+1) mod NREQ upward with wrap.
  - Latch its x/y into div_x/div_y, store gnt id, set last=id, div_run<=1, go to RUN.
  - If req is zero, stay in IDLE.
- RUN:
  - div_run stays high.
  - On the first ce edge where div_stall==0: res<=div_z, ack[id]<=1, div_run<=0, go to DONE.
  - This occurs 26 ce edges after the grant edge.
- DONE:
  - ack cleared on the next ce edge.
  - div_run stays 0 for this cycle so the divider step counter returns to 0.
  - Go to IDLE.
- Throughput and latency: grant edge to ack-visible is 26 edges; back-to-back operations complete one every 28 ce edges.
- Requests asserted during RUN or DONE wait; arbitration happens only in IDLE.
- If a requester drops req mid-operation, the operation still completes and ack still pulses; the result is simply not consumed.
- Operands arriving at x_in/y_in after the grant have no effect; the latched values are used.
- Simultaneous requests: the round-robin order guarantees no requester waits more than NREQ-1 operations.
- Reset mid-RUN aborts the operation: no ack is issued and res is cleared.

Optional Feature:
FPDIV_ZERO_BYPASS_EN
- When defined, in IDLE the arbiter checks the winning operands before starting the divider:
  - x exponent (bits 30:23) == 0: res<=0.
  - Otherwise, y exponent == 0: res<={x[31]^y[31], 8'hFF, 23'b0}.
  - In either case: ack[id] asserts on the next edge, state goes directly to DONE, and div_run never rises.
  - Total bypass latency is 1 edge plus the DONE cycle.
- When not defined, all operations go through the divider. The results are identical; only the latency differs.

Decomposition:
- Package fp_div_pkg holds:
  - state encoding IDLE/RUN/DONE (2-bit);
  - DIV_STEPS=25;
  - EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31;
  - INF_MAG=31'h7F800000.
- One sub-module, rr_arbiter (NREQ, IDW): inputs req and last; outputs any and gnt_id. Purely combinational, instantiated once.

Test Plan:
- Single req[0]: x=0x3F800000 (1.0), y=0x40000000 (2.0) -> ack[0] 26 edges after grant, res=0x3F000000; div_run high for exactly 26 cycles, then low for at least 1 cycle.
- req[0] and req[1] asserted together and held, with 6.0/3.0 (0x40C00000/0x40400000) and 1.0/2.0 -> ack[0] first with res=0x40000000, ack[1] 28 edges later with 0x3F000000; repeat with both held and verify strict alternation.
- Divide by zero: x=0xBF800000, y=0x00000000 -> res=0xFF800000. Without the macro this takes 26 edges; with FPDIV_ZERO_BYPASS_EN it takes 1 edge and div_run stays 0.
- ce toggled low for 10 random cycles during RUN -> ack is delayed by exactly 10 cycles and res is unchanged.
- rst pulsed low at edge 12 of RUN -> div_run=0 and ack=0 immediately, res=0; the next request completes normally with the correct quotient.
- x_in changed to 0x41200000 two cycles after the grant -> res still reflects the operands latched at the grant.
